// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
//   Steps through the nibbles of a held hex value, one per refresh slot, and
//   drives the matching active-low anode. Each slot opens with an all-off guard
//   interval. New values are only taken at frame boundaries.
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   value       hex value, nibble i shown on digit i (0 = rightmost)
//   value_valid 1-cycle strobe capturing value into the pending buffer
//   digit_en    per-digit enable mask, 0 keeps that digit dark
//   digit       nibble for the current slot (to the hex-to-segment decoder)
//   anodes      active-low anode enables, at most one low
//   frame_start 1-cycle pulse on the first cycle of slot 0
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    value_valid,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] active, active_nxt, pending;
    logic                    pend_flag;
    logic                    slot_end, boundary;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   lz_blank, anodes_nxt;
    logic [3:0]              digit_nxt;

    // Slot timer and digit index; boundary marks the edge that enters slot 0.
    always_comb begin
        slot_end = (cnt == CNT_LAST);
        boundary = slot_end && (idx == IDX_LAST);
        cnt_nxt  = slot_end ? '0 : cnt + CW'(1);
        idx_nxt  = idx;
        if (slot_end)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        // A strobe on the boundary edge lands in pending; the transfer
        // uses what was already pending.
        active_nxt = (boundary && pend_flag) ? pending : active;
    end

    // Leading-zero mask: digit i is blank when it and every digit above it
    // are zero. Built from the value the next slot will display.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (active_nxt[4*i +: 4] == 4'h0);
            lz_blank[i] = (LZ_SUPPRESS != 0) && (i != 0) && zero_above;
        end
    end

    // Next state and registered outputs, all aligned with the cnt update.
    always_comb begin
        state_nxt = state;
        case (state)
            GUARD:   if (cnt_nxt >= CNT_BLANK) state_nxt = SHOW;
            SHOW:    if (cnt_nxt == '0)        state_nxt = GUARD;
            default: state_nxt = GUARD;
        endcase
        anodes_nxt = '1;
        if (state_nxt == SHOW && digit_en[idx_nxt] && !lz_blank[idx_nxt])
            anodes_nxt[idx_nxt] = 1'b0;
        // Digit only changes at slot start while the anodes are dark.
        digit_nxt = digit;
        if (cnt_nxt == '0)
            digit_nxt = active_nxt[4*idx_nxt +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            state       <= GUARD;
            active      <= '0;
            pending     <= '0;
            pend_flag   <= 1'b0;
            digit       <= 4'h0;
            anodes      <= '1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            state       <= state_nxt;
            active      <= active_nxt;
            digit       <= digit_nxt;
            anodes      <= anodes_nxt;
            frame_start <= boundary;
            if (value_valid) begin
                pending   <= value;
                pend_flag <= 1'b1;
            end else if (boundary) begin
                pend_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two instances (plain and leading-zero
// suppressing) share stimulus and are checked every cycle against a model
// that derives slot position from elapsed cycles since reset.
module tb_seven_seg_scanner;
    localparam int N = 4, RD = 4, BL = 1, FR = N * RD;

    logic        clk = 1'b0;
    logic        rst, value_valid;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  digit0, digit1, anodes0, anodes1;
    logic        fs0, fs1;

    int n_cmp = 0, n_err = 0;

    // model state
    int          t;
    logic [15:0] m_active, m_pending;
    bit          m_flag;
    logic [3:0]  m_en;

    seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .digit_en(digit_en),
        .digit(digit0), .anodes(anodes0), .frame_start(fs0));
    seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .digit_en(digit_en),
        .digit(digit1), .anodes(anodes1), .frame_start(fs1));

    always #5 clk = ~clk;

    // Expected {digit, anodes, frame_start} at elapsed cycle t.
    function automatic logic [8:0] exp_out(bit lz);
        int         slot_cnt = t % RD;
        int         slot_idx = (t / RD) % N;
        logic [3:0] an = 4'hF;
        logic [15:0] sh = m_active >> (4 * slot_idx);
        bit         blank = lz && slot_idx != 0 && sh == 16'h0;
        if (slot_cnt >= BL && m_en[slot_idx] && !blank) an[slot_idx] = 1'b0;
        return {sh[3:0], an, (t != 0 && t % FR == 0)};
    endfunction

    task automatic tick(input logic vv, input logic [15:0] v, input logic r);
        value_valid = vv; value = v; rst = r;
        @(posedge clk);
        if (r) begin
            t = 0; m_active = 0; m_pending = 0; m_flag = 0;
        end else begin
            t++;
            if (t % FR == 0 && m_flag) begin m_active = m_pending; m_flag = 0; end
            if (vv) begin m_pending = v; m_flag = 1; end
        end
        m_en = digit_en;
        #1;
        value_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic advance_to(input int phase);
        int guard = 0;
        while (t % FR != phase && guard < 2 * FR) begin tick(0, 16'h0, 0); guard++; end
    endtask

    task automatic test_reset();
        tick(0, 16'h0, 1);
        tick(0, 16'h0, 1);
        n_cmp += 2;
        if ({digit0, anodes0, fs0} !== {4'h0, 4'hF, 1'b0}) begin
            n_err++; $display("FAIL reset dut0 got=%h want=%h", {digit0, anodes0, fs0}, {4'h0, 4'hF, 1'b0});
        end
        if ({digit1, anodes1, fs1} !== {4'h0, 4'hF, 1'b0}) begin
            n_err++; $display("FAIL reset dut1 got=%h want=%h", {digit1, anodes1, fs1}, {4'h0, 4'hF, 1'b0});
        end
    endtask

    task automatic test_basic();
        logic [3:0] nib [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
        tick(1, 16'h1A2F, 0);
        advance_to(0);
        n_cmp++;
        if (fs0 !== 1'b1) begin n_err++; $display("FAIL basic_fs got=%b want=1", fs0); end
        for (int s = 0; s < N; s++) begin
            n_cmp += 3;
            if (anodes0 !== 4'hF) begin n_err++; $display("FAIL basic_guard slot=%0d got=%b want=1111", s, anodes0); end
            if (digit0 !== nib[s]) begin n_err++; $display("FAIL basic_digit slot=%0d got=%h want=%h", s, digit0, nib[s]); end
            tick(0, 16'h0, 0);
            if (anodes0 !== ~(4'b1 << s)) begin n_err++; $display("FAIL basic_show slot=%0d got=%b want=%b", s, anodes0, ~(4'b1 << s)); end
            repeat (RD - 1) tick(0, 16'h0, 0);
        end
        for (int k = 0; k < 2 * FR; k++) begin
            tick(0, 16'h0, 0);
            n_cmp++;
            if ({digit0, anodes0, fs0} !== exp_out(0)) begin
                n_err++; $display("FAIL basic_run t=%0d got=%h want=%h", t, {digit0, anodes0, fs0}, exp_out(0));
            end
        end
    endtask

    task automatic test_midframe();
        advance_to(9);
        tick(1, 16'h1234, 0);
        for (int k = 0; k < FR + 4; k++) begin
            tick(0, 16'h0, 0);
            n_cmp++;
            if ({digit0, anodes0, fs0} !== exp_out(0)) begin
                n_err++; $display("FAIL midframe t=%0d got=%h want=%h", t, {digit0, anodes0, fs0}, exp_out(0));
            end
            if (t % FR == FR - 1) begin
                n_cmp++;
                if (digit0 !== 4'h1) begin n_err++; $display("FAIL midframe_old got=%h want=1", digit0); end
            end
            if (t % FR == 0) begin
                n_cmp++;
                if (digit0 !== 4'h4) begin n_err++; $display("FAIL midframe_new got=%h want=4", digit0); end
            end
        end
    endtask

    task automatic test_double();
        advance_to(3);
        tick(1, 16'hAAAA, 0);
        advance_to(7);
        tick(1, 16'h5555, 0);
        advance_to(0);
        n_cmp++;
        if (digit0 !== 4'h5) begin n_err++; $display("FAIL double_last got=%h want=5", digit0); end
        // strobe while frame_start is high: waits for the following frame
        tick(1, 16'h9876, 0);
        for (int k = 0; k < FR; k++) begin
            tick(0, 16'h0, 0);
            n_cmp++;
            if ({digit0, anodes0, fs0} !== exp_out(0)) begin
                n_err++; $display("FAIL double t=%0d got=%h want=%h", t, {digit0, anodes0, fs0}, exp_out(0));
            end
            if (t % FR == 12) begin
                n_cmp++;
                if (digit0 !== 4'h5) begin n_err++; $display("FAIL double_defer got=%h want=5", digit0); end
            end
        end
        n_cmp++;
        if (digit0 !== 4'h6) begin n_err++; $display("FAIL double_next got=%h want=6", digit0); end
    endtask

    task automatic test_lz();
        tick(1, 16'h0030, 0);
        advance_to(0);
        for (int k = 0; k < FR; k++) begin
            tick(0, 16'h0, 0);
            n_cmp += 2;
            if ({digit1, anodes1, fs1} !== exp_out(1)) begin
                n_err++; $display("FAIL lz_30 t=%0d got=%h want=%h", t, {digit1, anodes1, fs1}, exp_out(1));
            end
            if ((t % FR) / RD >= 2 && anodes1 !== 4'hF) begin
                n_err++; $display("FAIL lz_dark t=%0d got=%b want=1111", t, anodes1);
            end
        end
        tick(1, 16'h0000, 0);
        advance_to(1);
        n_cmp++;
        if (anodes1 !== 4'b1110) begin n_err++; $display("FAIL lz_zero_d0 got=%b want=1110", anodes1); end
        for (int k = 0; k < FR; k++) begin
            tick(0, 16'h0, 0);
            n_cmp++;
            if ({digit1, anodes1, fs1} !== exp_out(1)) begin
                n_err++; $display("FAIL lz_0 t=%0d got=%h want=%h", t, {digit1, anodes1, fs1}, exp_out(1));
            end
        end
    endtask

    task automatic test_digit_en();
        tick(1, 16'h4321, 0);
        digit_en = 4'b0101;
        for (int k = 0; k < 2 * FR; k++) begin
            tick(0, 16'h0, 0);
            n_cmp += 2;
            if ({digit0, anodes0, fs0} !== exp_out(0)) begin
                n_err++; $display("FAIL en_mask t=%0d got=%h want=%h", t, {digit0, anodes0, fs0}, exp_out(0));
            end
            if (anodes0[1] !== 1'b1 || anodes0[3] !== 1'b1) begin
                n_err++; $display("FAIL en_dark t=%0d got=%b want=1x1x", t, anodes0);
            end
        end
        advance_to(1);
        digit_en = 4'b0100;
        tick(0, 16'h0, 0);
        n_cmp++;
        if (anodes0 !== 4'hF) begin n_err++; $display("FAIL en_clear got=%b want=1111", anodes0); end
        digit_en = 4'hF;
    endtask

    task automatic test_reset_mid();
        tick(1, 16'hBEEF, 0);
        advance_to(9);
        tick(0, 16'h0, 1);
        n_cmp++;
        if ({digit0, anodes0, fs0} !== {4'h0, 4'hF, 1'b0}) begin
            n_err++; $display("FAIL rstmid_vals got=%h want=%h", {digit0, anodes0, fs0}, {4'h0, 4'hF, 1'b0});
        end
        for (int k = 0; k < 2 * FR; k++) begin
            tick(0, 16'h0, 0);
            n_cmp += 2;
            if ({digit0, anodes0, fs0} !== exp_out(0)) begin
                n_err++; $display("FAIL rstmid t=%0d got=%h want=%h", t, {digit0, anodes0, fs0}, exp_out(0));
            end
            if ($countones(~anodes0) > 1 || digit0 !== 4'h0) begin
                n_err++; $display("FAIL rstmid_dark t=%0d anodes=%b digit=%h want digit 0", t, anodes0, digit0);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom);
            tick($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 99) == 0);
            n_cmp += 3;
            if ({digit0, anodes0, fs0} !== exp_out(0)) begin
                n_err++; $display("FAIL rand0 t=%0d got=%h want=%h", t, {digit0, anodes0, fs0}, exp_out(0));
            end
            if ({digit1, anodes1, fs1} !== exp_out(1)) begin
                n_err++; $display("FAIL rand1 t=%0d got=%h want=%h", t, {digit1, anodes1, fs1}, exp_out(1));
            end
            if ($countones(~anodes0) > 1 || $countones(~anodes1) > 1) begin
                n_err++; $display("FAIL rand_onehot t=%0d got=%b/%b want <=1 low", t, anodes0, anodes1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; value_valid = 1'b0; value = 16'h0; digit_en = 4'hF;
        t = 0; m_active = 0; m_pending = 0; m_flag = 0; m_en = 4'hF;
        test_reset();
        test_basic();
        test_midframe();
        test_double();
        test_lz();
        test_digit_en();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
